// File: rtl/phase_pkg.sv
// ---------------------------------------------------------------------------
// phase_pkg
// Shared definitions for the phase tracker: error codes, the four legal
// phase encodings of the producer's one-hot-or-zero register, and the
// producer's next-phase bit equations.
// ---------------------------------------------------------------------------
package phase_pkg;

    // Error code reported for the first error since reset or clear.
    typedef enum logic [1:0] {
        NONE         = 2'd0,  // no error recorded
        ILLEGAL      = 2'd1,  // state not one-hot-or-zero
        NO_EN_CHANGE = 2'd2,  // state changed while enable was low
        BAD_STEP     = 2'd3   // state advanced to the wrong phase
    } err_code_t;

    // Legal producer encodings, in rotation order.
    localparam logic [2:0] P0 = 3'b000;
    localparam logic [2:0] P1 = 3'b001;
    localparam logic [2:0] P2 = 3'b010;
    localparam logic [2:0] P3 = 3'b100;

    // Producer's next-state equations. For legal inputs this yields the
    // rotation P0->P1->P2->P3->P0; for illegal inputs it reproduces exactly
    // what the producer hardware would do, so the prediction stays aligned.
    function automatic logic [2:0] next_phase(input logic [2:0] cur);
        return {cur[1], cur[0], cur == P0};
    endfunction

endpackage : phase_pkg

// File: rtl/phase_decode.sv
// ---------------------------------------------------------------------------
// phase_decode
// Combinational decoder from the producer's one-hot-or-zero phase register
// to a binary phase index, plus a legality flag.
//
// Ports:
//   state_i  [2:0]  producer phase register
//   phase_o  [1:0]  binary phase (000->0, 001->1, 010->2, 100->3, else 0)
//   legal_o         1 when state_i is one-hot-or-zero
// ---------------------------------------------------------------------------
module phase_decode
    import phase_pkg::*;
(
    input  logic [2:0] state_i,
    output logic [1:0] phase_o,
    output logic       legal_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        phase_o = 2'd0;
        legal_o = 1'b1;
        case (state_i)
            P0:      phase_o = 2'd0;
            P1:      phase_o = 2'd1;
            P2:      phase_o = 2'd2;
            P3:      phase_o = 2'd3;
            default: legal_o = 1'b0;
        endcase
    end

endmodule : phase_decode

// File: rtl/phase_tracker.sv
// ---------------------------------------------------------------------------
// phase_tracker
// Downstream monitor for the producer's 3-bit one-hot-or-zero phase register.
// Every cycle it samples state/en, predicts the next legal phase from the
// previous sample, and reports the binary phase, rotation completions and a
// sticky, saturating error record. All outputs are registered (1-cycle
// latency from the sampling edge).
//
// Parameters:
//   CNT_W               width of the rotation counter (wraps)
//   ERR_W               width of the error counter (saturates)
//   CHECK_STATE_ONEHOT  enables the embedded $onehot0 assertion on state;
//                       clear it in environments that inject bad encodings
//
// Ports:
//   clk                 clock, posedge
//   rst                 synchronous active-low reset, shared with producer
//   en                  producer enable
//   state     [2:0]     producer phase register
//   clr_err             synchronous clear of the error record
//   phase     [1:0]     binary phase of the sampled state
//   wrap                one-cycle pulse on a legal 100->000 transition
//   rot_cnt   [CNT_W]   number of wrap pulses, modulo 2^CNT_W
//   err                 sticky error flag
//   err_code  [1:0]     code of the first error since reset/clear
//   err_cnt   [ERR_W]   errors since reset/clear, saturating
// ---------------------------------------------------------------------------
module phase_tracker
    import phase_pkg::*;
#(
    parameter int CNT_W              = 8,
    parameter int ERR_W              = 4,
    parameter bit CHECK_STATE_ONEHOT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       state,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             wrap,
    output logic [CNT_W-1:0] rot_cnt,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [ERR_W-1:0] err_cnt
);

    // Prediction registers: last sampled state and enable.
    logic [2:0]       prev_state_q;
    logic             prev_en_q;

    // Output registers and their next-state values.
    logic [1:0]       phase_q;
    logic             wrap_q,     wrap_d;
    logic [CNT_W-1:0] rot_cnt_q,  rot_cnt_d;
    logic             err_q,      err_d;
    err_code_t        err_code_q, err_code_d;
    logic [ERR_W-1:0] err_cnt_q,  err_cnt_d;

    // Decoded view of the current sample.
    logic [1:0]       dec_phase;
    logic             dec_legal;

    logic [2:0]       exp_state;
    err_code_t        chk_code;

    phase_decode u_decode (
        .state_i (state),
        .phase_o (dec_phase),
        .legal_o (dec_legal)
    );

    // Check priority: illegal encoding beats change-without-enable, which
    // beats wrong-step. Only one of the last two can apply for a given
    // prev_en, but the explicit order keeps the intent readable.
    always_comb begin
        exp_state = prev_en_q ? next_phase(prev_state_q) : prev_state_q;
        chk_code  = NONE;
        if (!dec_legal) begin
            chk_code = ILLEGAL;
        end else if (!prev_en_q && (state != prev_state_q)) begin
            chk_code = NO_EN_CHANGE;
        end else if (prev_en_q && (state != exp_state)) begin
            chk_code = BAD_STEP;
        end
    end

    // Error record: the clear is applied first and a same-cycle error is
    // then recorded on top of the cleared state, so clear+error leaves
    // err=1, the new code, and a count of one.
    always_comb begin
        // NOTE: blocking assignments here let each step build on the one
        // before it (clear, then record) within a single evaluation.
        err_d      = err_q;
        err_code_d = err_code_q;
        err_cnt_d  = err_cnt_q;
        if (clr_err) begin
            err_d      = 1'b0;
            err_code_d = NONE;
            err_cnt_d  = '0;
        end
        if (chk_code != NONE) begin
            if (!err_d) begin
                err_code_d = chk_code;
            end
            err_d = 1'b1;
            if (err_cnt_d != '1) begin
                err_cnt_d = err_cnt_d + ERR_W'(1);
            end
        end
    end

    // A completed rotation needs a clean 100->000 step with enable high.
    assign wrap_d    = prev_en_q && (prev_state_q == P3) && (state == P0)
                       && (chk_code == NONE);
    assign rot_cnt_d = rot_cnt_q + CNT_W'(wrap_d);

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only (synchronous), so it
        // sits inside the clocked branch rather than in the sensitivity list.
        if (!rst) begin
            prev_state_q <= P0;
            prev_en_q    <= 1'b0;
            phase_q      <= 2'd0;
            wrap_q       <= 1'b0;
            rot_cnt_q    <= '0;
            err_q        <= 1'b0;
            err_code_q   <= NONE;
            err_cnt_q    <= '0;
        end else begin
            prev_state_q <= state;
            prev_en_q    <= en;
            phase_q      <= dec_phase;
            wrap_q       <= wrap_d;
            rot_cnt_q    <= rot_cnt_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign phase    = phase_q;
    assign wrap     = wrap_q;
    assign rot_cnt  = rot_cnt_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign err_cnt  = err_cnt_q;

    // ---------------------------------------------------------------------
    // Embedded properties, all inactive while reset is asserted.
    // ---------------------------------------------------------------------
    generate
        if (CHECK_STATE_ONEHOT) begin : g_state_chk
            a_state_onehot0: assert property (
                @(posedge clk) disable iff (!rst) $onehot0(state));
        end
    endgenerate

    a_wrap_phase0: assert property (
        @(posedge clk) disable iff (!rst) wrap_q |-> (phase_q == 2'd0));

    // The count may only drop across an edge that applied clear or reset.
    a_err_cnt_mono: assert property (
        @(posedge clk) disable iff (!rst)
        ($past(rst) && !$past(clr_err)) |-> (err_cnt_q >= $past(err_cnt_q)));

    a_rose_err_code: assert property (
        @(posedge clk) disable iff (!rst) $rose(err_q) |-> (err_code_q != NONE));

endmodule : phase_tracker

// File: tb/tb_phase_tracker.sv
// ---------------------------------------------------------------------------
// tb_phase_tracker
// Self-checking bench for phase_tracker: a directed vector table, hand-written
// multi-cycle sequences (saturation, clear, counter wrap, mid-rotation reset)
// and a randomized producer checked against a behavioural model.
// ---------------------------------------------------------------------------
module tb_phase_tracker;

    localparam int CNT_W   = 2;
    localparam int ERR_W   = 4;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
    localparam int ROT_MOD = 1 << CNT_W;

    logic             clk     = 1'b0;
    logic             rst     = 1'b0;
    logic             en      = 1'b0;
    logic [2:0]       state   = 3'b000;
    logic             clr_err = 1'b0;
    logic [1:0]       phase;
    logic             wrap;
    logic [CNT_W-1:0] rot_cnt;
    logic             err;
    logic [1:0]       err_code;
    logic [ERR_W-1:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Illegal encodings are injected deliberately, so the input-side
    // one-hot property is switched off for this instance.
    phase_tracker #(
        .CNT_W              (CNT_W),
        .ERR_W              (ERR_W),
        .CHECK_STATE_ONEHOT (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .state    (state),
        .clr_err  (clr_err),
        .phase    (phase),
        .wrap     (wrap),
        .rot_cnt  (rot_cnt),
        .err      (err),
        .err_code (err_code),
        .err_cnt  (err_cnt)
    );

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // ------------------------- behavioural model -------------------------
    int m_prev, m_prev_en, m_phase, m_wrap, m_rot, m_err, m_code, m_cnt;

    function automatic int nxt(input int x);
        return ((x << 1) & 7) | ((x == 0) ? 1 : 0);
    endfunction

    function automatic int phase_of(input int s);
        case (s)
            1:       return 1;
            2:       return 2;
            4:       return 3;
            default: return 0;
        endcase
    endfunction

    task automatic model_update(input logic r, input logic e,
                                input logic [2:0] s, input logic c);
        int code;
        int expv;
        bit legal;
        if (!r) begin
            m_prev = 0; m_prev_en = 0; m_phase = 0; m_wrap = 0;
            m_rot = 0; m_err = 0; m_code = 0; m_cnt = 0;
            return;
        end
        legal = ($countones(s) <= 1);
        expv  = (m_prev_en != 0) ? nxt(m_prev) : m_prev;
        if (!legal)                              code = 1;
        else if (m_prev_en == 0 && s != m_prev)  code = 2;
        else if (m_prev_en != 0 && s != expv)    code = 3;
        else                                     code = 0;
        if (c) begin
            m_err = 0; m_code = 0; m_cnt = 0;
        end
        if (code != 0) begin
            if (m_err == 0) m_code = code;
            m_err = 1;
            m_cnt = (m_cnt >= ERR_MAX) ? ERR_MAX : m_cnt + 1;
        end
        m_wrap    = (m_prev_en != 0 && m_prev == 4 && s == 0 && code == 0) ? 1 : 0;
        m_rot     = (m_rot + m_wrap) % ROT_MOD;
        m_phase   = legal ? phase_of(int'(s)) : 0;
        m_prev    = int'(s);
        m_prev_en = int'(e);
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic step(input logic r, input logic e, input logic [2:0] s,
                        input logic c);
        rst = r; en = e; state = s; clr_err = c;
        model_update(r, e, s, c);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input int cyc);
        check($sformatf("rnd%0d_phase", cyc),    32'(phase),    32'(m_phase));
        check($sformatf("rnd%0d_wrap", cyc),     32'(wrap),     32'(m_wrap));
        check($sformatf("rnd%0d_rot_cnt", cyc),  32'(rot_cnt),  32'(m_rot));
        check($sformatf("rnd%0d_err", cyc),      32'(err),      32'(m_err));
        check($sformatf("rnd%0d_err_code", cyc), 32'(err_code), 32'(m_code));
        check($sformatf("rnd%0d_err_cnt", cyc),  32'(err_cnt),  32'(m_cnt));
    endtask

    // --------------------------- vector table ----------------------------
    typedef struct {
        logic             rst;
        logic             en;
        logic [2:0]       state;
        logic             clr;
        logic [1:0]       phase;
        logic             wrap;
        logic [CNT_W-1:0] rot;
        logic             err;
        logic [1:0]       code;
        logic [ERR_W-1:0] cnt;
    } vec_t;

    function automatic vec_t mk(input int r, input int e, input int s, input int c,
                                input int ph, input int w, input int rot,
                                input int er, input int cd, input int cn);
        vec_t v;
        v.rst = 1'(r);   v.en = 1'(e);     v.state = 3'(s);  v.clr = 1'(c);
        v.phase = 2'(ph); v.wrap = 1'(w);  v.rot = CNT_W'(rot);
        v.err = 1'(er);  v.code = 2'(cd); v.cnt = ERR_W'(cn);
        return v;
    endfunction

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    initial begin
        logic [2:0] prod;
        logic [2:0] cur;
        logic       r, e, c;
        logic [2:0] s;

        //            rst en st  clr | ph wr rot er cd cn
        vecs[0]  = mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // reset
        vecs[1]  = mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0,   0, 0, 0, 0, 0, 0);  // first edge vs 000
        vecs[3]  = mk(1, 1, 1, 0,   1, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 1, 2, 0,   2, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 1, 4, 0,   3, 0, 0, 0, 0, 0);
        vecs[6]  = mk(1, 1, 0, 0,   0, 1, 1, 0, 0, 0);  // first wrap
        vecs[7]  = mk(1, 1, 1, 0,   1, 0, 1, 0, 0, 0);
        vecs[8]  = mk(1, 1, 2, 0,   2, 0, 1, 0, 0, 0);
        vecs[9]  = mk(1, 1, 4, 0,   3, 0, 1, 0, 0, 0);
        vecs[10] = mk(1, 0, 0, 0,   0, 1, 2, 0, 0, 0);  // second wrap
        vecs[11] = mk(1, 0, 3, 0,   0, 0, 2, 1, 1, 1);  // illegal 011
        vecs[12] = mk(1, 0, 0, 1,   0, 0, 2, 1, 2, 1);  // clear + new error
        vecs[13] = mk(1, 0, 0, 1,   0, 0, 2, 0, 0, 0);  // clean clear
        vecs[14] = mk(1, 0, 1, 0,   1, 0, 2, 1, 2, 1);  // change without en
        vecs[15] = mk(1, 1, 1, 1,   1, 0, 2, 0, 0, 0);
        vecs[16] = mk(1, 1, 4, 0,   3, 0, 2, 1, 3, 1);  // 001->100 bad step
        vecs[17] = mk(1, 1, 6, 0,   0, 0, 2, 1, 3, 2);  // 110: code holds

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].state, vecs[i].clr);
            check($sformatf("vec%0d_phase", i),    32'(phase),    32'(vecs[i].phase));
            check($sformatf("vec%0d_wrap", i),     32'(wrap),     32'(vecs[i].wrap));
            check($sformatf("vec%0d_rot_cnt", i),  32'(rot_cnt),  32'(vecs[i].rot));
            check($sformatf("vec%0d_err", i),      32'(err),      32'(vecs[i].err));
            check($sformatf("vec%0d_err_code", i), 32'(err_code), 32'(vecs[i].code));
            check($sformatf("vec%0d_err_cnt", i),  32'(err_cnt),  32'(vecs[i].cnt));
        end

        // ---- 20 consecutive errors: count saturates, first code kept ----
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, 3'b011, 1'b0);
            check($sformatf("sat%0d_err_cnt", i), 32'(err_cnt),
                  (2 + i > ERR_MAX) ? ERR_MAX : 2 + i);
        end
        check("sat_err_code", 32'(err_code), 32'd3);
        step(1'b1, 1'b0, 3'b000, 1'b0);  // 011->000 without enable: still an error
        check("sat_hold_err_cnt", 32'(err_cnt), ERR_MAX);
        check("sat_hold_err", 32'(err), 32'd1);
        step(1'b1, 1'b0, 3'b000, 1'b1);  // clear with no error
        check("clr_err", 32'(err), 32'd0);
        check("clr_err_code", 32'(err_code), 32'd0);
        check("clr_err_cnt", 32'(err_cnt), 32'd0);

        // ---- five rotations on a 2-bit counter, then mid-rotation reset ----
        step(1'b0, 1'b0, 3'b000, 1'b0);
        check("rot_reset_rot_cnt", 32'(rot_cnt), 32'd0);
        cur = 3'b000;
        for (int k = 0; k <= 20; k++) begin
            step(1'b1, 1'b1, cur, 1'b0);
            cur = 3'(nxt(int'(cur)));
        end
        check("rot5_rot_cnt", 32'(rot_cnt), 32'd1);
        check("rot5_wrap", 32'(wrap), 32'd1);
        check("rot5_err", 32'(err), 32'd0);
        step(1'b1, 1'b1, 3'b001, 1'b0);
        step(1'b1, 1'b1, 3'b010, 1'b0);
        check("mid_phase", 32'(phase), 32'd2);
        step(1'b0, 1'b1, 3'b100, 1'b0);  // reset lands mid-rotation
        check("midrst_rot_cnt", 32'(rot_cnt), 32'd0);
        check("midrst_phase", 32'(phase), 32'd0);
        check("midrst_wrap", 32'(wrap), 32'd0);
        step(1'b1, 1'b0, 3'b000, 1'b0);  // producer restarted at 000
        check("release_err", 32'(err), 32'd0);
        check("release_err_cnt", 32'(err_cnt), 32'd0);
        check("release_phase", 32'(phase), 32'd0);
        check("release_rot_cnt", 32'(rot_cnt), 32'd0);

        // ---- randomized producer with occasional faults, clears, resets ----
        prod = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 63) != 0);
            e = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 23) == 0);
            s = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : prod;
            step(r, e, s, c);
            check_model(i);
            prod = !r ? 3'b000 : (e ? 3'(nxt(int'(s))) : s);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_phase_tracker
